// File: rtl/lock_sequencer.sv
// Keypad lock control FSM: digit capture, code evaluation, failure counting, entry/lockout timers.
// Optional build macro LOCK_CODE_PROG_EN adds a programmable code register and a prog_sw input.
module lock_sequencer #(
  parameter int unsigned TICK_DIV      = 100000,
  parameter int unsigned ENTRY_TIMEOUT = 7500,
  parameter int unsigned LOCKOUT_TICKS = 5000,
  parameter int unsigned MAX_FAILS     = 2,
  parameter logic [15:0] CODE          = 16'h5285
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  digit_sel,
  input  logic [3:0]  digit_val,
  input  logic        enter_sw,
  input  logic        relock_sw,
`ifdef LOCK_CODE_PROG_EN
  input  logic        prog_sw,
`endif
  output logic [15:0] entered_code,
  output logic [3:0]  digit_valid,
  output logic [1:0]  disp_mode,
  output logic        unlocked,
  output logic [1:0]  fail_count
);

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ENTRY_W = $clog2(ENTRY_TIMEOUT + 1);
  localparam int LOCK_W  = $clog2(LOCKOUT_TICKS + 1);

  localparam logic [TICK_W-1:0]  TICK_LAST   = TICK_W'(TICK_DIV - 1);
  localparam logic [ENTRY_W-1:0] ENTRY_LIMIT = ENTRY_W'(ENTRY_TIMEOUT);
  localparam logic [LOCK_W-1:0]  LOCK_LIMIT  = LOCK_W'(LOCKOUT_TICKS);
  localparam logic [1:0]         FAIL_LIMIT  = 2'(MAX_FAILS);

  // Encoding doubles as the display mode driven downstream.
  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_OPEN    = 2'd2,
    ST_SUSPEND = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [ENTRY_W-1:0]  entry_timer_q, entry_timer_d;
  logic [LOCK_W-1:0]   lock_timer_q, lock_timer_d;
  logic [15:0]         entered_code_q, entered_code_d;
  logic [3:0]          digit_valid_q, digit_valid_d;
  logic [1:0]          fail_count_q, fail_count_d;
  logic [1:0]          disp_mode_q, disp_mode_d;
  logic                unlocked_q, unlocked_d;
  logic [3:0]          digit_prev_q;
  logic                enter_prev_q, relock_prev_q;
  logic [15:0]         code_cur;

  logic tick, digit_ev, enter_ev, relock_ev;
  logic do_eval, do_capture;
  logic [ENTRY_W-1:0] entry_inc;
  logic [LOCK_W-1:0]  lock_inc;
  logic [1:0]         fail_inc;

`ifdef LOCK_CODE_PROG_EN
  logic [15:0] code_q, code_d;
  logic        prog_prev_q, prog_ev;
  assign prog_ev  = prog_prev_q & ~prog_sw;
  assign code_cur = code_q;
`else
  assign code_cur = CODE;
`endif

  assign tick      = (tick_cnt_q == TICK_LAST);
  assign digit_ev  = $onehot(digit_sel) && |(digit_sel & ~digit_prev_q);
  assign enter_ev  = enter_prev_q & ~enter_sw;
  assign relock_ev = relock_prev_q & ~relock_sw;
  assign entry_inc = entry_timer_q + 1'b1;
  assign lock_inc  = lock_timer_q + 1'b1;
  assign fail_inc  = fail_count_q + 2'd1;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d        = state_q;
    tick_cnt_d     = tick ? '0 : tick_cnt_q + 1'b1;
    entry_timer_d  = entry_timer_q;
    lock_timer_d   = lock_timer_q;
    entered_code_d = entered_code_q;
    digit_valid_d  = digit_valid_q;
    fail_count_d   = fail_count_q;
    do_eval        = 1'b0;
    do_capture     = 1'b0;
`ifdef LOCK_CODE_PROG_EN
    code_d         = code_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (enter_ev) begin
          do_eval = 1'b1;
        end else if (digit_ev) begin
          do_capture = 1'b1;
          state_d    = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        // Timeout outranks a simultaneous enter; enter outranks a simultaneous digit.
        if (tick && entry_inc == ENTRY_LIMIT) begin
          state_d        = ST_SUSPEND;
          entered_code_d = '0;
          digit_valid_d  = '0;
          fail_count_d   = '0;
        end else if (enter_ev) begin
          do_eval = 1'b1;
        end else begin
          do_capture = digit_ev;
          if (tick) entry_timer_d = entry_inc;
        end
      end
      ST_OPEN: begin
        if (relock_ev) begin
          state_d        = ST_IDLE;
          entered_code_d = '0;
          digit_valid_d  = '0;
`ifdef LOCK_CODE_PROG_EN
        end else if (prog_ev) begin
          if (digit_valid_q == 4'hF) code_d = entered_code_q;
          entered_code_d = '0;
          digit_valid_d  = '0;
        end else begin
          do_capture = digit_ev;
`endif
        end
      end
      ST_SUSPEND: begin
        if (tick) begin
          if (lock_inc == LOCK_LIMIT) state_d = ST_IDLE;
          else                        lock_timer_d = lock_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_capture) begin
      for (int i = 0; i < 4; i++) begin
        if (digit_sel[i]) entered_code_d[(3-i)*4 +: 4] = digit_val;
      end
      digit_valid_d = digit_valid_q | digit_sel;
    end

    if (do_eval) begin
      entered_code_d = '0;
      digit_valid_d  = '0;
      if (digit_valid_q == 4'hF && entered_code_q == code_cur) begin
        state_d      = ST_OPEN;
        fail_count_d = '0;
      end else if (fail_inc == FAIL_LIMIT) begin
        state_d      = ST_SUSPEND;
        fail_count_d = '0;
      end else begin
        state_d      = ST_IDLE;
        fail_count_d = fail_inc;
      end
    end

    if (state_d != state_q) begin
      entry_timer_d = '0;
      lock_timer_d  = '0;
    end

    disp_mode_d = state_d;
    unlocked_d  = (state_d == ST_OPEN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      tick_cnt_q     <= '0;
      entry_timer_q  <= '0;
      lock_timer_q   <= '0;
      entered_code_q <= '0;
      digit_valid_q  <= '0;
      fail_count_q   <= '0;
      disp_mode_q    <= 2'd1;
      unlocked_q     <= 1'b0;
      digit_prev_q   <= '0;
      enter_prev_q   <= 1'b0;
      relock_prev_q  <= 1'b0;
`ifdef LOCK_CODE_PROG_EN
      code_q         <= CODE;
      prog_prev_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      entry_timer_q  <= entry_timer_d;
      lock_timer_q   <= lock_timer_d;
      entered_code_q <= entered_code_d;
      digit_valid_q  <= digit_valid_d;
      fail_count_q   <= fail_count_d;
      disp_mode_q    <= disp_mode_d;
      unlocked_q     <= unlocked_d;
      digit_prev_q   <= digit_sel;
      enter_prev_q   <= enter_sw;
      relock_prev_q  <= relock_sw;
`ifdef LOCK_CODE_PROG_EN
      code_q         <= code_d;
      prog_prev_q    <= prog_sw;
`endif
    end
  end

  assign entered_code = entered_code_q;
  assign digit_valid  = digit_valid_q;
  assign disp_mode    = disp_mode_q;
  assign unlocked     = unlocked_q;
  assign fail_count   = fail_count_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed self-checking bench for lock_sequencer with shortened timers.
// Build with LOCK_CODE_PROG_EN defined to also exercise code programming.
module tb_lock_sequencer;

  localparam int TICK_DIV      = 4;
  localparam int ENTRY_TIMEOUT = 20;
  localparam int LOCKOUT_TICKS = 10;
  localparam int MAX_FAILS     = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  digit_sel, digit_val;
  logic        enter_sw, relock_sw;
`ifdef LOCK_CODE_PROG_EN
  logic        prog_sw;
`endif
  logic [15:0] entered_code;
  logic [3:0]  digit_valid;
  logic [1:0]  disp_mode;
  logic        unlocked;
  logic [1:0]  fail_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  lock_sequencer #(
    .TICK_DIV(TICK_DIV), .ENTRY_TIMEOUT(ENTRY_TIMEOUT), .LOCKOUT_TICKS(LOCKOUT_TICKS),
    .MAX_FAILS(MAX_FAILS), .CODE(16'h5285)
  ) dut (
    .clk(clk), .rst(rst),
    .digit_sel(digit_sel), .digit_val(digit_val),
    .enter_sw(enter_sw), .relock_sw(relock_sw),
`ifdef LOCK_CODE_PROG_EN
    .prog_sw(prog_sw),
`endif
    .entered_code(entered_code), .digit_valid(digit_valid),
    .disp_mode(disp_mode), .unlocked(unlocked), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  // Posedges since reset; the DUT tick fires on the edge that makes cyc a multiple of TICK_DIV.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic press(input int pos, input logic [3:0] val);
    @(negedge clk);
    digit_val = val;
    digit_sel = 4'b0001 << pos;
    @(negedge clk);
    digit_sel = 4'b0000;
  endtask

  task automatic key_code(input logic [15:0] c);
    press(0, c[15:12]);
    press(1, c[11:8]);
    press(2, c[7:4]);
    press(3, c[3:0]);
  endtask

  task automatic enter_release();
    @(negedge clk); enter_sw = 1'b1;
    @(negedge clk); enter_sw = 1'b0;
    @(negedge clk);
  endtask

  task automatic relock_release();
    @(negedge clk); relock_sw = 1'b1;
    @(negedge clk); relock_sw = 1'b0;
    @(negedge clk);
  endtask

  // Enter release and a fresh digit press land on the same clock edge.
  task automatic enter_with_digit(input int pos, input logic [3:0] val);
    @(negedge clk); enter_sw = 1'b1;
    @(negedge clk); enter_sw = 1'b0; digit_sel = 4'b0001 << pos; digit_val = val;
    @(negedge clk); digit_sel = 4'b0000;
  endtask

  task automatic wait_disp(input string tag, input logic [1:0] exp, input int budget);
    int k = 0;
    while (disp_mode !== exp && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, disp_mode, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, t1, t_to;
    rst = 1'b1; digit_sel = '0; digit_val = '0; enter_sw = 1'b0; relock_sw = 1'b0;
`ifdef LOCK_CODE_PROG_EN
    prog_sw = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_disp", disp_mode, 2'd1);
    check("rst_unlocked", unlocked, 1'b0);
    check("rst_fail", fail_count, 2'd0);
    check("rst_valid", digit_valid, 4'h0);
    check("rst_code", entered_code, 16'h0);
    rst = 1'b0;

    // Correct code opens, extra events in OPEN are ignored, relock returns to CLOSED.
    key_code(16'h5285);
    check("entry_code", entered_code, 16'h5285);
    check("entry_valid", digit_valid, 4'hF);
    check("entry_disp", disp_mode, 2'd0);
    enter_release();
    check("open_disp", disp_mode, 2'd2);
    check("open_unlocked", unlocked, 1'b1);
    check("open_valid_clr", digit_valid, 4'h0);
    press(0, 4'h7);
`ifdef LOCK_CODE_PROG_EN
    check("open_digit", digit_valid, 4'b0001);
`else
    check("open_digit", digit_valid, 4'b0000);
`endif
    enter_release();
    check("open_enter_ign", disp_mode, 2'd2);
    relock_release();
    check("relock_disp", disp_mode, 2'd1);
    check("relock_unlocked", unlocked, 1'b0);

    // Two wrong codes -> SUSPEND, lockout of 10 ticks.
    key_code(16'h1234);
    enter_release();
    check("fail1_count", fail_count, 2'd1);
    check("fail1_disp", disp_mode, 2'd1);
    key_code(16'h1234);
    enter_release();
    check("fail2_disp", disp_mode, 2'd3);
    check("fail2_count", fail_count, 2'd0);
    press(0, 4'h5);
    check("susp_digit_ign", digit_valid, 4'h0);
    repeat (33) @(negedge clk);
    check("susp_hold", disp_mode, 2'd3);
    wait_disp("susp_exit", 2'd1, 8);

    // Digit coinciding with enter is discarded: 5,2,8 + (5 & enter) is a mismatch.
    press(0, 4'h5); press(1, 4'h2); press(2, 4'h8);
    enter_with_digit(3, 4'h5);
    check("dig_enter_disp", disp_mode, 2'd1);
    check("dig_enter_fail", fail_count, 2'd1);
    check("dig_enter_valid", digit_valid, 4'h0);
    key_code(16'h5285);
    enter_with_digit(0, 4'h1);
    check("dig_enter_open", disp_mode, 2'd2);
    check("dig_enter_fclr", fail_count, 2'd0);
    relock_release();

    // Multi-hot ignored; held button captures exactly once.
    @(negedge clk); digit_sel = 4'b0011; digit_val = 4'hA;
    @(negedge clk); digit_sel = 4'b0000;
    @(negedge clk);
    check("multihot_valid", digit_valid, 4'h0);
    check("multihot_disp", disp_mode, 2'd1);
    @(negedge clk); digit_sel = 4'b0100; digit_val = 4'h7;
    @(negedge clk); digit_val = 4'h9;
    repeat (3) @(negedge clk);
    digit_sel = 4'b0000;
    @(negedge clk);
    check("held_code", entered_code, 16'h0070);
    check("held_valid", digit_valid, 4'b0100);
    enter_release();
    check("held_fail", fail_count, 2'd1);

    // Asynchronous reset in the middle of an entry.
    press(2, 4'h6);
    check("pre_rst_disp", disp_mode, 2'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_disp", disp_mode, 2'd1);
    check("async_rst_valid", digit_valid, 4'h0);
    check("async_rst_fail", fail_count, 2'd0);
    check("async_rst_code", entered_code, 16'h0);
    @(negedge clk); rst = 1'b0;

    // Entry timeout, with an enter release landing on the timeout edge.
    press(1, 4'h3);
    e    = cyc;
    t1   = (e / TICK_DIV + 1) * TICK_DIV;
    t_to = t1 + (ENTRY_TIMEOUT - 1) * TICK_DIV;
    check("to_entry_disp", disp_mode, 2'd0);
    while (cyc < t_to - 3) @(negedge clk);
    enter_sw = 1'b1;
    while (cyc < t_to - 1) @(negedge clk);
    check("to_pre_disp", disp_mode, 2'd0);
    enter_sw = 1'b0;
    @(negedge clk);
    check("to_disp", disp_mode, 2'd3);
    check("to_valid", digit_valid, 4'h0);
    check("to_fail", fail_count, 2'd0);
    wait_disp("to_exit", 2'd1, 60);
    check("to_exit_fail", fail_count, 2'd0);

`ifdef LOCK_CODE_PROG_EN
    key_code(16'h5285);
    enter_release();
    check("prog_open", disp_mode, 2'd2);
    key_code(16'h1111);
    check("prog_valid", digit_valid, 4'hF);
    check("prog_disp", disp_mode, 2'd2);
    @(negedge clk); prog_sw = 1'b1;
    @(negedge clk); prog_sw = 1'b0;
    @(negedge clk);
    check("prog_clr", digit_valid, 4'h0);
    relock_release();
    key_code(16'h5285);
    enter_release();
    check("prog_old_fail", fail_count, 2'd1);
    check("prog_old_disp", disp_mode, 2'd1);
    key_code(16'h1111);
    enter_release();
    check("prog_new_open", disp_mode, 2'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
